// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that lets two requesters share one data-memory port.
// Build option DMEM_ARB_ALIGN_CHECK_EN answers misaligned half/word requests with an error and never issues them.
module dmem_arbiter #(
   parameter int addrWidth = 32,
   parameter int dataWidth = 32,
   parameter int rdLatency = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 r0Valid,
   output logic                 r0Ready,
   input  logic [addrWidth-1:0] r0Addr,
   input  logic [dataWidth-1:0] r0Wdata,
   input  logic [2:0]           r0MemOp,
   input  logic                 r0We,
   output logic                 r0Rvalid,
   output logic [dataWidth-1:0] r0Rdata,
   output logic                 r0Err,
   input  logic                 r1Valid,
   output logic                 r1Ready,
   input  logic [addrWidth-1:0] r1Addr,
   input  logic [dataWidth-1:0] r1Wdata,
   input  logic [2:0]           r1MemOp,
   input  logic                 r1We,
   output logic                 r1Rvalid,
   output logic [dataWidth-1:0] r1Rdata,
   output logic                 r1Err,
   output logic [addrWidth-1:0] memAddr,
   output logic [dataWidth-1:0] memDin,
   output logic [2:0]           memOp,
   output logic                 memWe,
   input  logic [dataWidth-1:0] memDout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t               state_q, state_d;
   logic                 lastGrant_q, lastGrant_d;
   logic [addrWidth-1:0] addr_q, addr_d;
   logic [dataWidth-1:0] wdata_q, wdata_d;
   logic [2:0]           op_q, op_d;
   logic                 we_q, we_d;
   logic                 id_q, id_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [1:0]           rvalid_q, rvalid_d;
   logic [1:0]           err_q, err_d;
   logic [dataWidth-1:0] rdata0_q, rdata0_d;
   logic [dataWidth-1:0] rdata1_q, rdata1_d;

   logic                 gnt;
   logic                 accept;
   logic [addrWidth-1:0] selAddr;
   logic [2:0]           selOp;
   logic                 misalign;
   logic                 respUpd;
   logic                 respId;
   logic [dataWidth-1:0] respData;

   // With both requesters valid, the one that did not win last time wins now.
   always_comb begin
      if (r0Valid && !r1Valid)      gnt = 1'b0;
      else if (r1Valid && !r0Valid) gnt = 1'b1;
      else                          gnt = ~lastGrant_q;
   end

   assign accept  = (state_q == IDLE) && (r0Valid || r1Valid);
   assign r0Ready = (state_q == IDLE) && r0Valid && !gnt;
   assign r1Ready = (state_q == IDLE) && r1Valid && gnt;
   assign selAddr = gnt ? r1Addr  : r0Addr;
   assign selOp   = gnt ? r1MemOp : r0MemOp;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      case (selOp)
         3'd1, 3'd5: misalign = selAddr[0];
         3'd2:       misalign = |selAddr[1:0];
         default:    misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      op_d        = op_q;
      we_d        = we_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      rvalid_d    = 2'b00;
      err_d       = 2'b00;
      respUpd     = 1'b0;
      respId      = id_q;
      respData    = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               lastGrant_d = gnt;
               addr_d      = selAddr;
               wdata_d     = gnt ? r1Wdata : r0Wdata;
               op_d        = selOp;
               we_d        = gnt ? r1We : r0We;
               id_d        = gnt;
               if (misalign) begin
                  // Misaligned: skip the memory entirely and answer with an error.
                  state_d     = RESP;
                  respUpd     = 1'b1;
                  respId      = gnt;
                  err_d[gnt]  = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = RESP;
               respUpd = 1'b1;
            end else begin
               state_d = WAIT;
               cnt_d   = 3'(rdLatency - 1);
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d  = RESP;
               respUpd  = 1'b1;
               respData = memDout;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      if (respUpd) begin
         rvalid_d[respId] = 1'b1;
         if (respId) rdata1_d = respData;
         else        rdata0_d = respData;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         op_q        <= '0;
         we_q        <= 1'b0;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         rvalid_q    <= '0;
         err_q       <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         op_q        <= op_d;
         we_q        <= we_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         rvalid_q    <= rvalid_d;
         err_q       <= err_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign memWe    = (state_q == ISSUE) && we_q;
   assign memAddr  = addr_q;
   assign memDin   = wdata_q;
   assign memOp    = op_q;
   assign r0Rvalid = rvalid_q[0];
   assign r1Rvalid = rvalid_q[1];
   assign r0Err    = err_q[0];
   assign r1Err    = err_q[1];
   assign r0Rdata  = rdata0_q;
   assign r1Rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two requesters, a word memory, and a transaction-level reference model.
module tb_dmem_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rstn;
   wire logic     r0Valid, r1Valid, r0We, r1We;
   wire logic [AW-1:0] r0Addr, r1Addr;
   wire logic [DW-1:0] r0Wdata, r1Wdata;
   wire logic [2:0]    r0MemOp, r1MemOp;
   logic          r0Ready, r1Ready, r0Rvalid, r1Rvalid, r0Err, r1Err, memWe;
   logic [DW-1:0] r0Rdata, r1Rdata, memDin, memDout;
   logic [AW-1:0] memAddr;
   logic [2:0]    memOp;

   // requester state
   bit            qV [2];
   bit            qWe [2];
   bit            acc [2];
   logic [AW-1:0] qAddr [2];
   logic [DW-1:0] qWd [2];
   logic [2:0]    qOp [2];
   bit            gen_en;

   assign r0Valid = qV[0];  assign r1Valid = qV[1];
   assign r0We    = qWe[0]; assign r1We    = qWe[1];
   assign r0Addr  = qAddr[0]; assign r1Addr = qAddr[1];
   assign r0Wdata = qWd[0];   assign r1Wdata = qWd[1];
   assign r0MemOp = qOp[0];   assign r1MemOp = qOp[1];

   dmem_arbiter #(.addrWidth(AW), .dataWidth(DW), .rdLatency(LAT)) dut (
      .clk(clk), .rstn(rstn),
      .r0Valid(r0Valid), .r0Ready(r0Ready), .r0Addr(r0Addr), .r0Wdata(r0Wdata),
      .r0MemOp(r0MemOp), .r0We(r0We), .r0Rvalid(r0Rvalid), .r0Rdata(r0Rdata), .r0Err(r0Err),
      .r1Valid(r1Valid), .r1Ready(r1Ready), .r1Addr(r1Addr), .r1Wdata(r1Wdata),
      .r1MemOp(r1MemOp), .r1We(r1We), .r1Rvalid(r1Rvalid), .r1Rdata(r1Rdata), .r1Err(r1Err),
      .memAddr(memAddr), .memDin(memDin), .memOp(memOp), .memWe(memWe), .memDout(memDout)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0107);
   endfunction

   // word memory with one-cycle read latency
   logic [DW-1:0] mem [0:63];
   always @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (memWe) begin
         mem[memAddr[7:2]] <= memDin;
      end
      memDout <= mem[memAddr[7:2]];
   end

   // reference model
   int            n_chk, n_err;
   int            cyc, busy_until;
   bit            lastG;
   logic [DW-1:0] shadow [0:63];
   logic [DW-1:0] last_rd [2];
   bit            resp_pending, resp_id, resp_err;
   int            resp_due;
   logic [DW-1:0] resp_data;
   bit            iss_pending, iss_we;
   int            iss_due;
   logic [AW-1:0] iss_addr;
   logic [DW-1:0] iss_wd;
   logic [2:0]    iss_op;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      lastG = 1'b1;
      busy_until = cyc;
      resp_pending = 1'b0;
      iss_pending = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
   endtask

   function automatic logic [2:0] pick_ld_op(input int k);
      case (k)
         0: return 3'd0; 1: return 3'd1; 2: return 3'd2;
         3: return 3'd4; 4: return 3'd5; default: return 3'($urandom_range(3, 7));
      endcase
   endfunction

   task automatic gen_req(input int n);
      qV[n]    = 1'b1;
      qWe[n]   = 1'($urandom_range(0, 1));
      qAddr[n] = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) qAddr[n][1:0] = 2'b00;
      qWd[n]   = $urandom;
      qOp[n]   = qWe[n] ? 3'($urandom_range(0, 2)) : pick_ld_op(int'($urandom_range(0, 5)));
   endtask

   task automatic drive();
      for (int n = 0; n < 2; n++) begin
         if (acc[n]) begin
            qV[n]  = 1'b0;
            acc[n] = 1'b0;
         end
         if (gen_en && !qV[n] && $urandom_range(0, 2) != 0) gen_req(n);
      end
   endtask

   task automatic do_accept(input bit g);
      logic [AW-1:0] a;
      bit mis;
      lastG  = g;
      acc[g] = 1'b1;
      a      = qAddr[g];
      mis    = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      if ((qOp[g] == 3'd1 || qOp[g] == 3'd5) && a[0]) mis = 1'b1;
      if (qOp[g] == 3'd2 && a[1:0] != 2'b00) mis = 1'b1;
`endif
      resp_pending = 1'b1;
      resp_id      = g;
      if (mis) begin
         resp_due   = cyc + 1;
         resp_data  = '0;
         resp_err   = 1'b1;
         busy_until = cyc + 2;
      end else begin
         resp_err    = 1'b0;
         iss_pending = 1'b1;
         iss_due     = cyc + 1;
         iss_addr    = a;
         iss_wd      = qWd[g];
         iss_op      = qOp[g];
         iss_we      = qWe[g];
         if (qWe[g]) begin
            shadow[a[7:2]] = qWd[g];
            resp_due   = cyc + 2;
            resp_data  = '0;
            busy_until = cyc + 3;
         end else begin
            resp_due   = cyc + LAT + 2;
            resp_data  = shadow[a[7:2]];
            busy_until = cyc + LAT + 3;
         end
      end
   endtask

   task automatic cycle_check();
      bit exRdy [2];
      bit exRv [2];
      bit g;
      bit exWe;
      exRdy[0] = 1'b0; exRdy[1] = 1'b0; g = 1'b0;
      if (cyc >= busy_until && (qV[0] || qV[1])) begin
         g = (qV[0] && qV[1]) ? ~lastG : qV[1];
         exRdy[g] = 1'b1;
      end
      check_val("r0Ready", 32'(r0Ready), 32'(exRdy[0]));
      check_val("r1Ready", 32'(r1Ready), 32'(exRdy[1]));
      exRv[0] = resp_pending && resp_due == cyc && !resp_id;
      exRv[1] = resp_pending && resp_due == cyc && resp_id;
      if (exRv[0] || exRv[1]) begin
         last_rd[resp_id] = resp_data;
         resp_pending = 1'b0;
      end
      check_val("r0Rvalid", 32'(r0Rvalid), 32'(exRv[0]));
      check_val("r1Rvalid", 32'(r1Rvalid), 32'(exRv[1]));
      check_val("r0Rdata", r0Rdata, last_rd[0]);
      check_val("r1Rdata", r1Rdata, last_rd[1]);
      check_val("r0Err", 32'(r0Err), 32'(exRv[0] && resp_err));
      check_val("r1Err", 32'(r1Err), 32'(exRv[1] && resp_err));
      exWe = iss_pending && iss_due == cyc && iss_we;
      check_val("memWe", 32'(memWe), 32'(exWe));
      if (iss_pending && iss_due == cyc) begin
         check_val("memAddr", memAddr, iss_addr);
         check_val("memOp", 32'(memOp), 32'(iss_op));
         check_val("memDin", memDin, iss_wd);
         iss_pending = 1'b0;
      end
      if (exRdy[0] || exRdy[1]) do_accept(g);
      cyc++;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         drive();
         @(negedge clk);
         cycle_check();
      end
   endtask

   task automatic drain();
      bit drained;
      gen_en  = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 60 && !drained; i++) begin
         run_cycles(1);
         drained = !qV[0] && !qV[1] && cyc >= busy_until && !resp_pending && !iss_pending;
      end
      check_val("drain", 32'(drained), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_memWe"}, 32'(memWe), 32'd0);
      check_val({tag, "_r0Rvalid"}, 32'(r0Rvalid), 32'd0);
      check_val({tag, "_r1Rvalid"}, 32'(r1Rvalid), 32'd0);
      check_val({tag, "_r0Rdata"}, r0Rdata, 32'd0);
      check_val({tag, "_r1Rdata"}, r1Rdata, 32'd0);
      check_val({tag, "_r0Err"}, 32'(r0Err), 32'd0);
      check_val({tag, "_memAddr"}, memAddr, 32'd0);
      check_val({tag, "_memOp"}, 32'(memOp), 32'd0);
      check_val({tag, "_memDin"}, memDin, 32'd0);
   endtask

   initial begin
      n_chk = 0; n_err = 0; cyc = 0;
      gen_en = 1'b1;
      for (int n = 0; n < 2; n++) begin
         qV[n] = 1'b0; qWe[n] = 1'b0; acc[n] = 1'b0;
         qAddr[n] = '0; qWd[n] = '0; qOp[n] = '0;
      end
      rstn = 1'b0;
      model_reset();
      @(negedge clk);
      check_idle_outputs("rst");
      @(posedge clk);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      cycle_check();

      run_cycles(400);
      drain();

      // load from r0, then reset while it sits in WAIT
      @(posedge clk); #1;
      qV[0] = 1'b1; qWe[0] = 1'b0; qAddr[0] = 32'h80; qOp[0] = 3'd0; qWd[0] = '0;
      @(negedge clk); cycle_check();
      check_val("ld_acc", 32'(acc[0]), 32'd1);
      @(posedge clk); #1; drive();
      @(negedge clk); cycle_check();
      @(posedge clk); #1;
      rstn = 1'b0;
      @(negedge clk);
      check_idle_outputs("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("midrst_hold");

      // request presented as reset releases must be accepted on the first edge
      @(posedge clk); #1;
      rstn = 1'b1;
      model_reset();
      acc[0] = 1'b0; acc[1] = 1'b0;
      qV[0] = 1'b1; qWe[0] = 1'b1; qAddr[0] = 32'h100; qWd[0] = 32'hDEADBEEF; qOp[0] = 3'd2;
      @(negedge clk); cycle_check();
      check_val("post_rst_acc", 32'(acc[0]), 32'd1);

      gen_en = 1'b1;
      run_cycles(400);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
